// File: rtl/control_pkg.sv
// Shared BN254 accelerator control types: instructions, ROM words,
// and the micro-op bundle handed to the Fp/Fp2 issue stage.
package CONTROL;

   typedef logic [6:0] operation_t;

   typedef struct packed {
      logic [3:0] end_mop_cnt;
      logic [2:0] cm;
      logic       me;
   } sub_op_t;

   typedef struct packed {
      operation_t op;
      sub_op_t    sub_op;
   } opcode_t;

   typedef struct packed {
      opcode_t    opcode;
      logic [6:0] dst;
      logic [6:0] src0;
      logic [6:0] src1;
   } instruction_t;

   typedef struct packed {
      logic [1:0] inve;
      logic [1:0] pos;
      logic [1:0] pom3;
      logic [1:0] pom2;
      logic [1:0] pom1;
      logic [3:0] pm;
      logic [2:0] cm;
      logic       offset_dst;
      logic       offset_src0;
      logic       offset_src1;
   } ctrl_sig_offset_t;

   typedef struct packed {
      logic [1:0] inve;
      logic [1:0] pos;
      logic [1:0] pom3;
      logic [1:0] pom2;
      logic [1:0] pom1;
      logic [3:0] pm;
      logic [2:0] cm;
      logic       me1;
      logic       me0;
   } ctrl_sig_t;

   typedef struct packed {
      ctrl_sig_t  csig;
      logic [8:0] dst;
      logic [8:0] src0;
      logic [8:0] src1;
   } micro_ops_t;

endpackage

// File: rtl/mop_sequencer_if.sv
// Instruction, microcode ROM and micro-op handshake bundle
// around the micro-op sequencer.
interface mop_sequencer_if;
   import CONTROL::*;

   logic             inst_valid;
   logic             inst_ready;
   instruction_t     inst;
   logic             rom_en;
   logic [10:0]      rom_addr;
   ctrl_sig_offset_t rom_data;
   logic             mop_valid;
   logic             mop_ready;
   micro_ops_t       mop;
   logic             mop_last;
   logic             busy;

   modport master (
      input  inst_valid, inst, rom_data, mop_ready,
      output inst_ready, rom_en, rom_addr,
      output mop_valid, mop, mop_last, busy
   );

   modport slave (
      output inst_valid, inst, rom_data, mop_ready,
      input  inst_ready, rom_en, rom_addr,
      input  mop_valid, mop, mop_last, busy
   );
endinterface

// File: rtl/mop_sequencer.sv
// Expands one accelerator instruction into end_mop_cnt+1 micro-ops
// using a synchronous microcode ROM, with valid/ready on both sides.
module mop_sequencer
   import CONTROL::*;
#(
   parameter int MOP_CNT_W  = 4,
   parameter int ROM_ADDR_W = 11
) (
   input logic            clk,
   input logic            rst,
   mop_sequencer_if.master bus
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state, state_nxt;
   logic [MOP_CNT_W-1:0]  idx, idx_nxt;
   instruction_t          ir;
   logic                  adv, last, issue, rdy, accept;
   logic [ROM_ADDR_W-1:0] addr;

   logic       s1_valid, s1_last, s1_me;
   logic [2:0] s1_cm;
   logic [6:0] s1_dst, s1_src0, s1_src1;

   ctrl_sig_offset_t rd;
   micro_ops_t       mop_nxt;

   assign adv  = !bus.mop_valid | bus.mop_ready;
   assign last = idx == ir.opcode.sub_op.end_mop_cnt;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      issue     = 1'b0;
      rdy       = 1'b0;
      unique case (state)
         IDLE: begin
            rdy = 1'b1;
            if (bus.inst_valid) begin
               state_nxt = ISSUE;
               idx_nxt   = '0;
            end
         end
         ISSUE: begin
            issue = adv;
            rdy   = last & adv;
            if (adv) begin
               if (!last) begin
                  idx_nxt = idx + 1'b1;
               end else begin
                  idx_nxt   = '0;
                  state_nxt = bus.inst_valid ? ISSUE : IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   assign accept = bus.inst_valid & rdy & !rst;
   assign addr   = rst ? '0 : {ir.opcode.op, idx};

   assign bus.inst_ready = rdy & !rst;
   assign bus.rom_en     = issue & !rst;
   assign bus.rom_addr   = addr;
   assign bus.busy       = (state == ISSUE) | s1_valid | bus.mop_valid;

   // ROM cm of zero means "use the instruction's own cm"
   always_comb begin
      rd                = bus.rom_data;
      mop_nxt           = '0;
      mop_nxt.csig.inve = rd.inve;
      mop_nxt.csig.pos  = rd.pos;
      mop_nxt.csig.pom3 = rd.pom3;
      mop_nxt.csig.pom2 = rd.pom2;
      mop_nxt.csig.pom1 = rd.pom1;
      mop_nxt.csig.pm   = rd.pm;
      mop_nxt.csig.cm   = (rd.cm != 3'd0) ? rd.cm : s1_cm;
      mop_nxt.csig.me1  = s1_me;
      mop_nxt.csig.me0  = s1_me;
      mop_nxt.dst       = {s1_dst, 1'b0, rd.offset_dst};
      mop_nxt.src0      = {s1_src0, 1'b0, rd.offset_src0};
      mop_nxt.src1      = {s1_src1, 1'b0, rd.offset_src1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir            <= '0;
         s1_valid      <= 1'b0;
         s1_last       <= 1'b0;
         s1_me         <= 1'b0;
         s1_cm         <= '0;
         s1_dst        <= '0;
         s1_src0       <= '0;
         s1_src1       <= '0;
         bus.mop_valid <= 1'b0;
         bus.mop_last  <= 1'b0;
         bus.mop       <= '0;
      end else begin
         if (accept) ir <= bus.inst;
         if (adv) begin
            s1_valid      <= issue;
            bus.mop_valid <= s1_valid;
            bus.mop_last  <= s1_valid & s1_last;
            if (s1_valid) bus.mop <= mop_nxt;
            if (issue) begin
               s1_last <= last;
               s1_me   <= ir.opcode.sub_op.me;
               s1_cm   <= ir.opcode.sub_op.cm;
               s1_dst  <= ir.dst;
               s1_src0 <= ir.src0;
               s1_src1 <= ir.src1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mop_sequencer.sv
// Randomized bench for mop_sequencer: queue-based scoreboard of
// expected ROM addresses and micro-ops plus directed scenarios.
module tb_mop_sequencer;
   import CONTROL::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mop_sequencer_if bus ();

   mop_sequencer #(.MOP_CNT_W(4), .ROM_ADDR_W(11)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      micro_ops_t m;
      logic       l;
   } exp_t;

   int n_cmp = 0;
   int n_err = 0;
   int pops  = 0;
   int rmode = 0;

   logic [19:0] rom_mem [0:2047];
   logic [10:0] aq [$];
   exp_t        mq [$];
   exp_t        e;
   logic        prev_stall = 1'b0;
   micro_ops_t  prev_mop;
   logic        prev_last;
   logic        adv_m;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic micro_ops_t exp_mop(input instruction_t i,
                                          input int k);
      ctrl_sig_offset_t r;
      micro_ops_t m;
      r = rom_mem[{i.opcode.op, 4'(k)}];
      m.csig.inve = r.inve;
      m.csig.pos  = r.pos;
      m.csig.pom3 = r.pom3;
      m.csig.pom2 = r.pom2;
      m.csig.pom1 = r.pom1;
      m.csig.pm   = r.pm;
      m.csig.cm   = (r.cm == 0) ? i.opcode.sub_op.cm : r.cm;
      m.csig.me1  = i.opcode.sub_op.me;
      m.csig.me0  = i.opcode.sub_op.me;
      m.dst  = {i.dst, 1'b0, r.offset_dst};
      m.src0 = {i.src0, 1'b0, r.offset_src0};
      m.src1 = {i.src1, 1'b0, r.offset_src1};
      return m;
   endfunction

   // synchronous microcode ROM that holds its output when disabled
   initial bus.rom_data = '0;
   always @(posedge clk)
      if (bus.rom_en) bus.rom_data <= rom_mem[bus.rom_addr];

   initial begin
      int c;
      c = 0;
      bus.mop_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         c++;
         case (rmode)
            1:       bus.mop_ready = (c % 3) == 0;
            2:       bus.mop_ready = 1'($urandom_range(0, 1));
            default: bus.mop_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         aq.delete();
         mq.delete();
         prev_stall = 1'b0;
      end else begin
         adv_m = !bus.mop_valid || bus.mop_ready;
         chk("inst_ready", bus.inst_ready,
             (aq.size() == 0) || (aq.size() == 1 && adv_m));
         chk("rom_en", bus.rom_en, aq.size() != 0 && adv_m);
         if (prev_stall)
            chk("stall_hold", {bus.mop_valid, bus.mop_last, bus.mop},
                {1'b1, prev_last, prev_mop});
         if (bus.rom_en && aq.size() != 0)
            chk("rom_addr", bus.rom_addr, aq.pop_front());
         if (bus.mop_valid && bus.mop_ready) begin
            if (mq.size() == 0) begin
               chk("extra_mop", 1, 0);
            end else begin
               e = mq.pop_front();
               chk("mop", bus.mop, e.m);
               chk("mop_last", bus.mop_last, e.l);
               pops++;
            end
         end
         prev_stall = bus.mop_valid && !bus.mop_ready;
         prev_mop   = bus.mop;
         prev_last  = bus.mop_last;
         if (bus.inst_valid && bus.inst_ready) begin
            for (int k = 0; k <= int'(bus.inst.opcode.sub_op.end_mop_cnt); k++) begin
               aq.push_back({bus.inst.opcode.op, 4'(k)});
               e.m = exp_mop(bus.inst, k);
               e.l = (k == int'(bus.inst.opcode.sub_op.end_mop_cnt));
               mq.push_back(e);
            end
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the accept edge
   task automatic send(input instruction_t i);
      int n;
      n = 0;
      bus.inst = i;
      bus.inst_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.inst_ready && n < 200);
      if (!bus.inst_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((aq.size() != 0 || mq.size() != 0 || bus.busy) && n < 500);
      chk("drain_done", aq.size() + mq.size() + 32'(bus.busy), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic instruction_t mk(input logic [6:0] op,
      input logic [3:0] cnt, input logic [2:0] cm, input logic me,
      input logic [6:0] d, input logic [6:0] s0, input logic [6:0] s1);
      instruction_t i;
      i.opcode.op = op;
      i.opcode.sub_op.end_mop_cnt = cnt;
      i.opcode.sub_op.cm = cm;
      i.opcode.sub_op.me = me;
      i.dst = d;
      i.src0 = s0;
      i.src1 = s1;
      return i;
   endfunction

   initial begin
      int n, base;
      logic [4:0] vv, ll;
      logic [63:0] r64;
      ctrl_sig_offset_t w;

      for (int a = 0; a < 2048; a++) rom_mem[a] = 20'($urandom);
      w = '0;
      w.offset_dst = 1'b1;
      for (int k = 0; k < 3; k++) rom_mem[{7'h12, 4'(k)}] = w;
      w = '0;
      rom_mem[{7'h21, 4'd0}] = w;
      w.cm = 3'd2;
      rom_mem[{7'h21, 4'd1}] = w;

      bus.inst_valid = 1'b0;
      bus.inst = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mop_valid", bus.mop_valid, 0);
      chk("rst_mop_last", bus.mop_last, 0);
      chk("rst_mop", bus.mop, 0);
      chk("rst_rom_en", bus.rom_en, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_inst_ready", bus.inst_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single instruction with latency and operand formation
      send(mk(7'h12, 4'd2, 3'd0, 1'b0, 7'h05, 7'h10, 7'h7F));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mop_valid && n < 20);
      chk("latency", n - 1, 2);
      chk("single_dst", bus.mop.dst, 9'h015);
      chk("single_src0", bus.mop.src0, 9'h040);
      chk("single_src1", bus.mop.src1, 9'h1FC);
      drain();

      // cm override and me fan-out
      send(mk(7'h21, 4'd1, 3'd5, 1'b1, 7'h01, 7'h02, 7'h03));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mop_valid && n < 20);
      chk("cm_from_sub_op", bus.mop.csig.cm, 5);
      chk("me_pair", {bus.mop.csig.me1, bus.mop.csig.me0}, 2'b11);
      @(negedge clk);
      chk("cm_from_rom", bus.mop.csig.cm, 2);
      drain();

      // back-to-back, no bubble
      send(mk(7'h40, 4'd0, 3'd1, 1'b0, 7'h11, 7'h22, 7'h33));
      send(mk(7'h41, 4'd3, 3'd3, 1'b1, 7'h44, 7'h55, 7'h66));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mop_valid && n < 20);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         vv[k] = bus.mop_valid;
         ll[k] = bus.mop_last;
      end
      chk("b2b_valid", vv, 5'b11111);
      chk("b2b_last", ll, 5'b10001);
      drain();

      // backpressure 1,0,0 pattern
      rmode = 1;
      send(mk(7'h50, 4'd4, 3'd2, 1'b0, 7'h0A, 7'h0B, 7'h0C));
      drain();
      rmode = 0;

      // maximum count
      base = pops;
      send(mk(7'h60, 4'd15, 3'd4, 1'b1, 7'h3C, 7'h2D, 7'h1E));
      drain();
      chk("max_count", pops - base, 16);

      // reset in the middle of an instruction
      base = pops;
      send(mk(7'h33, 4'd5, 3'd6, 1'b0, 7'h12, 7'h34, 7'h56));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pops - base < 2 && n < 50);
      chk("mid_two_mops", pops - base, 2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_inst_ready", bus.inst_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_mop_valid", bus.mop_valid, 0);
      chk("mid_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      base = pops;
      send(mk(7'h34, 4'd2, 3'd0, 1'b1, 7'h07, 7'h08, 7'h09));
      drain();
      chk("after_rst_count", pops - base, 3);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         rmode = $urandom_range(0, 2);
         r64 = {$urandom(), $urandom()};
         send(instruction_t'(r64[35:0]));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      rmode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mop_sequencer.md
# mop_sequencer

Expands one accelerator instruction (`CONTROL::instruction_t`) into a stream of `end_mop_cnt+1` micro-operations (`CONTROL::micro_ops_t`) for the BN254 datapath. It sits between the instruction fetch/UART loader and the Fp/Fp2 arithmetic issue stage. It reads per-micro-op control words from an external synchronous microcode ROM and resolves register addresses from the instruction operands plus the ROM offset bits. It applies valid/ready backpressure on both sides.

## Interface
- `MOP_CNT_W`, default 4: width of the micro-op index. Must equal the width of `sub_op.end_mop_cnt`.
- `ROM_ADDR_W`, default 11: ROM address width, `$bits(operation_t)+MOP_CNT_W`.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_valid` in 1: instruction offered.
- `inst_ready` out 1: instruction accepted when `inst_valid & inst_ready`.
- `inst` in 36: `CONTROL::instruction_t`.
- `rom_en` out 1: ROM read enable. The ROM holds `rom_data` when `rom_en` is low.
- `rom_addr` out 11: `{inst.opcode.op, idx}`.
- `rom_data` in 20: `CONTROL::ctrl_sig_offset_t`. Valid one cycle after the `rom_en` edge.
- `mop_valid` out 1: micro-op available.
- `mop_ready` in 1: consumer accepts the micro-op.
- `mop` out 46: `CONTROL::micro_ops_t`.
- `mop_last` out 1: marks the final micro-op of the instruction.
- `busy` out 1: high if any instruction or micro-op is held internally.

## Operation
- **Advance condition:** `adv = !mop_valid | mop_ready`. All pipeline registers move only when `adv` is high.
- **States:** IDLE and ISSUE.
  - **IDLE:**
    - `inst_ready`=1.
    - On accept, the block latches `inst`, sets `idx`=0 and moves to ISSUE.
  - **ISSUE:**
    - `rom_addr={op, idx}` and `rom_en=adv`.
    - On `adv`, the stage-1 register captures `{dst, src0, src1, sub_op.cm, sub_op.me, last=(idx==end_mop_cnt)}` with `s1_valid`=1.
    - On the same `adv`, `idx` increments, or the FSM exits when `last`.
  - **ISSUE exit:**
    - `inst_ready` = (`idx==end_mop_cnt` & `adv`). This allows back-to-back instructions with no bubble.
    - If accepted on that cycle, the FSM stays in ISSUE with `idx`=0. Otherwise it goes to IDLE.
  - When no issue happens on an `adv` cycle, `s1_valid` <= 0.
- **Output register** (on `adv`): `mop_valid<=s1_valid`, `mop_last<=s1_last`. The `mop` fields are:
  - `csig.inve/pos/pom3/pom2/pom1/pm` taken directly from `rom_data`.
  - `csig.cm` = `rom_data.cm` when nonzero, else the latched `sub_op.cm`.
  - `csig.me1 = csig.me0` = latched `sub_op.me`.
  - `dst = {inst.dst, 1'b0, rom_data.offset_dst}`. `src0` and `src1` are formed the same way with their own offsets.
- **Count:** an instruction emits exactly `end_mop_cnt+1` micro-ops (1..16). `end_mop_cnt=0` emits one micro-op with `mop_last`=1.
- `busy` = (state==ISSUE) | `s1_valid` | `mop_valid`.
- **Reset:** state=IDLE, `idx`=0, `s1_valid`=0. Reset values of outputs: `mop_valid`=0, `mop_last`=0, `mop`=0, `rom_en`=0, `rom_addr`=0, `busy`=0, `inst_ready`=0 during the reset cycle and 1 after it. A reset in the middle of an instruction discards all in-flight micro-ops. No partial micro-op appears after reset deasserts.
- **Simultaneous events:** the last micro-op output with `mop_ready` and a new instruction accept in the same cycle are legal. Both take effect at that edge.

## Timing
- **Latency:** an instruction accepted at edge E0 produces `rom_addr` for `idx`0 in the next cycle, is read by the ROM at E1, and registers into `mop` at E2. The first `mop_valid` is high 2 cycles after the accept edge.
- **Throughput:** 1 micro-op per cycle with no stall. An N-micro-op instruction occupies N issue cycles.
- **Stall:** while `mop_valid & !mop_ready`, the following are held stable:
  - `mop`, `mop_valid`, `mop_last`.
  - `rom_en`=0 and `rom_addr`.
  - `idx` and the stage-1 register.
- `inst_ready` is combinational from the state, `idx` and `mop_ready`. There is no combinational path from `inst_valid` to any output.

## Test plan
- **Single instruction:** op=7'h12, end_mop_cnt=2, dst=7'h05, src0=7'h10, src1=7'h7F, ROM returns offset_dst=1 and all other fields 0.
  - Expect 3 micro-ops.
  - Expect `rom_addr` 11'h120, 11'h121, 11'h122.
  - Expect `mop.dst`=9'h015, `src0`=9'h040, `src1`=9'h1FC.
  - Expect `mop_last` only on the third micro-op, and the first `mop_valid` 2 cycles after accept.
- **cm override:** sub_op.cm=3'd5 with ROM cm=0 gives `csig.cm`=5. ROM cm=3'd2 gives `csig.cm`=2. sub_op.me=1 gives me1=me0=1 on every micro-op.
- **Back-to-back:** two instructions with end_mop_cnt=0 and 3 and `mop_ready` held at 1. Expect 5 consecutive `mop_valid` cycles with no bubble and `mop_last` on micro-ops 1 and 5.
- **Backpressure:** end_mop_cnt=4 with `mop_ready` toggled 1,0,0,1,... Expect no lost or duplicated micro-op, `mop` stable while stalled, and `rom_en`=0 on stall cycles.
- **Max count:** end_mop_cnt=15. Expect 16 micro-ops, `idx` wrapping from 15 back to IDLE, and `inst_ready` low until the 16th issue cycle.
- **Reset mid-instruction:** assert `rst` after 2 of 6 micro-ops. Expect `mop_valid`=0 the following cycle, `busy`=0, and the next instruction to start cleanly at `idx` 0.
